// File: rtl/mrv1_issue_sched.sv
// mrv1_issue_sched: per-cycle round-robin thread picker for the multithreaded issue stage
// Holds a thread off after it issues a branch/jump until execute resolves it.
// Optional starvation priority when MRV1_ISSUE_SCHED_STARVE_EN is defined.
// Ports: clk_i/rst_i (sync, active-high); thr_en_i/thr_rdy_i/thr_conflict_i/thr_is_ctrl_i per thread;
// thr_fu_req_i one-hot FU request per thread; exec_fu_rdy_i per FU; exec_b_resolve_vld_i/_tid_i resolve;
// issue_vld_o/issue_tid_o/issue_gnt_o grant (combinational); thr_blocked_o registered hold-off mask.
module mrv1_issue_sched #(
  parameter int NUM_THREADS_P = 8,
  parameter int NUM_FU_P = 4,
  parameter int STARVE_LIMIT_P = 15,
  localparam int TID_WIDTH_LP = $clog2(NUM_THREADS_P)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_THREADS_P-1:0]          thr_en_i,
  input  logic [NUM_THREADS_P-1:0]          thr_rdy_i,
  input  logic [NUM_THREADS_P-1:0]          thr_conflict_i,
  input  logic [NUM_THREADS_P-1:0]          thr_is_ctrl_i,
  input  logic [NUM_THREADS_P*NUM_FU_P-1:0] thr_fu_req_i,
  input  logic [NUM_FU_P-1:0]               exec_fu_rdy_i,
  input  logic                              exec_b_resolve_vld_i,
  input  logic [TID_WIDTH_LP-1:0]           exec_b_resolve_tid_i,
  output logic                              issue_vld_o,
  output logic [TID_WIDTH_LP-1:0]           issue_tid_o,
  output logic [NUM_THREADS_P-1:0]          issue_gnt_o,
  output logic [NUM_THREADS_P-1:0]          thr_blocked_o
);
  logic [NUM_THREADS_P-1:0] blocked_q, elig, set_blk, clr_blk;
  logic [TID_WIDTH_LP-1:0] ptr_q, rr_tid, win_tid;
  logic rr_vld, win_vld;
  always_comb begin
    elig = '0;
    for (int t = 0; t < NUM_THREADS_P; t++)
      elig[t] = thr_en_i[t] & thr_rdy_i[t] & ~thr_conflict_i[t] & ~blocked_q[t]
                & |(thr_fu_req_i[t*NUM_FU_P +: NUM_FU_P] & exec_fu_rdy_i);
  end
  // Scan from farthest to nearest so the nearest eligible thread after ptr_q is written last.
  always_comb begin
    rr_vld = 1'b0;
    rr_tid = '0;
    for (int i = NUM_THREADS_P; i >= 1; i--)
      if (elig[(int'(ptr_q) + i) % NUM_THREADS_P]) begin
        rr_vld = 1'b1;
        rr_tid = TID_WIDTH_LP'((int'(ptr_q) + i) % NUM_THREADS_P);
      end
  end
`ifdef MRV1_ISSUE_SCHED_STARVE_EN
  localparam int WAIT_W_LP = $clog2(STARVE_LIMIT_P + 1);
  logic [WAIT_W_LP-1:0] wait_q [NUM_THREADS_P];
  logic st_vld;
  logic [TID_WIDTH_LP-1:0] st_tid;
  always_comb begin
    st_vld = 1'b0;
    st_tid = '0;
    for (int t = NUM_THREADS_P - 1; t >= 0; t--)
      if (elig[t] && wait_q[t] == WAIT_W_LP'(STARVE_LIMIT_P)) begin
        st_vld = 1'b1;
        st_tid = TID_WIDTH_LP'(t);
      end
  end
  assign win_vld = st_vld | rr_vld;
  assign win_tid = st_vld ? st_tid : rr_tid;
  always_ff @(posedge clk_i)
    for (int t = 0; t < NUM_THREADS_P; t++)
      if (rst_i || issue_gnt_o[t] || !(thr_en_i[t] && thr_rdy_i[t] && !blocked_q[t]))
        wait_q[t] <= '0;
      else if (wait_q[t] != WAIT_W_LP'(STARVE_LIMIT_P))
        wait_q[t] <= wait_q[t] + 1'b1;
`else
  localparam int unused_starve_limit_lp = STARVE_LIMIT_P;
  assign win_vld = rr_vld;
  assign win_tid = rr_tid;
`endif
  assign issue_vld_o = ~rst_i & win_vld;
  assign issue_tid_o = issue_vld_o ? win_tid : '0;
  assign issue_gnt_o = issue_vld_o ? NUM_THREADS_P'(1) << issue_tid_o : '0;
  assign set_blk = issue_gnt_o & thr_is_ctrl_i;
  assign clr_blk = (exec_b_resolve_vld_i && int'(exec_b_resolve_tid_i) < NUM_THREADS_P)
                   ? NUM_THREADS_P'(1) << exec_b_resolve_tid_i : '0;
  assign thr_blocked_o = blocked_q;
  always_ff @(posedge clk_i)
    if (rst_i) begin
      ptr_q <= TID_WIDTH_LP'(NUM_THREADS_P - 1);
      blocked_q <= '0;
    end else begin
      if (issue_vld_o) ptr_q <= issue_tid_o;
      blocked_q <= (blocked_q & ~clr_blk) | set_blk;
    end
endmodule
